bit_serial_seq: RTL and testbench

Sequencer for the bit-serial adder datapath (two parallel-load shift registers, carry flip-flop, 1-bit full adder, SIPO sum register). It accepts an operand pair through a ready/valid-style start handshake and drives the datapath's load, reset and SIPO-enable strobes for WIDTH bit-cycles. It then captures the parallel sum and final carry and presents them with a valid/ready result handshake. It sits between the issuing logic and one datapath instance.

---
 rtl/bit_serial_seq_if.sv | 25 ++
 rtl/bit_serial_seq.sv | 150 +++++++++++++++
 tb/tb_bit_serial_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_seq_if.sv
// Issue and result handshake bundle between the issuing logic and the bit-serial adder sequencer.
// The master drives requests and result acceptance; the slave (sequencer) answers.
interface bit_serial_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [WIDTH-1:0] result_sum;
    logic             result_cout;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output start, a_in, b_in, cin_in, result_ready,
        input  start_ready, result_sum, result_cout, result_valid
    );

    modport slave (
        input  start, a_in, b_in, cin_in, result_ready,
        output start_ready, result_sum, result_cout, result_valid
    );
endinterface

// File: rtl/bit_serial_seq.sv
// Sequencer for a bit-serial adder datapath: accepts an operand pair, strobes the datapath
// for WIDTH bit-cycles, then captures and presents the sum and final carry.
module bit_serial_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_serial_seq_if.slave      bus,
    output logic [WIDTH-1:0]     dp_a,
    output logic [WIDTH-1:0]     dp_b,
    output logic                 dp_cin,
    output logic                 dp_load,
    output logic                 dp_rst_shift,
    output logic                 dp_rst_ff,
    output logic                 dp_sipo_load,
    input  logic [WIDTH-1:0]     dp_sum,
    input  logic                 dp_cout,
    output logic                 busy,
    output logic [CNT_W-1:0]     bit_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_VALID
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dp_a_q, dp_a_d;
    logic [WIDTH-1:0] dp_b_q, dp_b_d;
    logic             dp_cin_q, dp_cin_d;
    logic [WIDTH-1:0] result_sum_q, result_sum_d;
    logic             result_cout_q, result_cout_d;
    logic             result_valid_q, result_valid_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             busy_q, busy_d;
    logic             start_ready_q, start_ready_d;
    logic             dp_load_q, dp_load_d;
    logic             dp_rst_ff_q, dp_rst_ff_d;
    logic             dp_sipo_load_q, dp_sipo_load_d;
    logic             dp_rst_shift_q, dp_rst_shift_d;

    // Strobes are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        state_d        = state_q;
        dp_a_d         = dp_a_q;
        dp_b_d         = dp_b_q;
        dp_cin_d       = dp_cin_q;
        result_sum_d   = result_sum_q;
        result_cout_d  = result_cout_q;
        bit_cnt_d      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dp_a_d   = bus.a_in;
                    dp_b_d   = bus.b_in;
                    dp_cin_d = bus.cin_in;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // dp_cout is combinational, so on the last bit it already holds the final carry.
                if (bit_cnt_q == LAST_BIT) begin
                    result_cout_d = dp_cout;
                    state_d       = S_CAPTURE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                result_sum_d = dp_sum;
                state_d      = S_VALID;
            end
            S_VALID: begin
                if (bus.result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_ready_d  = (state_d == S_IDLE);
        dp_rst_shift_d = (state_d == S_IDLE);
        dp_load_d      = (state_d == S_LOAD);
        dp_rst_ff_d    = (state_d == S_LOAD);
        dp_sipo_load_d = (state_d == S_SHIFT);
        busy_d         = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_CAPTURE);
        result_valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            dp_a_q         <= '0;
            dp_b_q         <= '0;
            dp_cin_q       <= 1'b0;
            result_sum_q   <= '0;
            result_cout_q  <= 1'b0;
            result_valid_q <= 1'b0;
            bit_cnt_q      <= '0;
            busy_q         <= 1'b0;
            start_ready_q  <= 1'b1;
            dp_load_q      <= 1'b0;
            dp_rst_ff_q    <= 1'b0;
            dp_sipo_load_q <= 1'b0;
            dp_rst_shift_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            dp_a_q         <= dp_a_d;
            dp_b_q         <= dp_b_d;
            dp_cin_q       <= dp_cin_d;
            result_sum_q   <= result_sum_d;
            result_cout_q  <= result_cout_d;
            result_valid_q <= result_valid_d;
            bit_cnt_q      <= bit_cnt_d;
            busy_q         <= busy_d;
            start_ready_q  <= start_ready_d;
            dp_load_q      <= dp_load_d;
            dp_rst_ff_q    <= dp_rst_ff_d;
            dp_sipo_load_q <= dp_sipo_load_d;
            dp_rst_shift_q <= dp_rst_shift_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_sum   = result_sum_q;
    assign bus.result_cout  = result_cout_q;
    assign bus.result_valid = result_valid_q;
    assign dp_a             = dp_a_q;
    assign dp_b             = dp_b_q;
    assign dp_cin           = dp_cin_q;
    assign dp_load          = dp_load_q;
    assign dp_rst_shift     = dp_rst_shift_q;
    assign dp_rst_ff        = dp_rst_ff_q;
    assign dp_sipo_load     = dp_sipo_load_q;
    assign busy             = busy_q;
    assign bit_cnt          = bit_cnt_q;

endmodule

// File: tb/tb_bit_serial_seq.sv
// Directed bench for bit_serial_seq with a behavioural bit-serial adder datapath attached.
module tb_bit_serial_seq;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] dp_a, dp_b, dp_sum;
    logic             dp_cin, dp_load, dp_rst_shift, dp_rst_ff, dp_sipo_load, dp_cout;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    bit_serial_seq_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_cin       (dp_cin),
        .dp_load      (dp_load),
        .dp_rst_shift (dp_rst_shift),
        .dp_rst_ff    (dp_rst_ff),
        .dp_sipo_load (dp_sipo_load),
        .dp_sum       (dp_sum),
        .dp_cout      (dp_cout),
        .busy         (busy),
        .bit_cnt      (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: two PISO shift registers, carry flop, full adder, SIPO sum register.
    logic [WIDTH-1:0] sh_a, sh_b, sipo;
    logic             carry;
    wire              sum_bit = sh_a[0] ^ sh_b[0] ^ carry;
    assign dp_cout = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    assign dp_sum  = sipo;

    always @(posedge clk) begin
        if (dp_rst_shift) begin
            sh_a <= '0;
            sh_b <= '0;
            sipo <= '0;
        end else if (dp_load) begin
            sh_a <= dp_a;
            sh_b <= dp_b;
        end else if (dp_sipo_load) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            sipo <= {sum_bit, sipo[WIDTH-1:1]};
        end
        if (dp_rst_ff)         carry <= dp_cin;
        else if (dp_sipo_load) carry <= dp_cout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to result_valid. A stray start with junk operands
    // is pulsed at cycle poke_at after accept (0 = none).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] exp_sum, input logic exp_cout, input int poke_at);
        int n = 1;
        int n_load = 0, n_rstff = 0, n_sipo = 0, n_busy = 0, first_sipo = 0, cnt_err = 0;
        bus.start  = 1'b1;
        bus.a_in   = a;
        bus.b_in   = b;
        bus.cin_in = cin;
        tick();
        bus.start = 1'b0;
        while (n < 40) begin
            if (n == poke_at) begin
                bus.start = 1'b1;
                bus.a_in  = ~a;
                bus.b_in  = ~b;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.result_valid) break;
            if (dp_load)   n_load++;
            if (dp_rst_ff) n_rstff++;
            if (busy)      n_busy++;
            if (dp_sipo_load) begin
                if (n_sipo == 0) first_sipo = n;
                if (bit_cnt != CNT_W'(n_sipo)) cnt_err++;
                n_sipo++;
            end else if (bit_cnt != '0) begin
                cnt_err++;
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        check("latency", n, 11);
        check("sum", bus.result_sum, exp_sum);
        check("cout", bus.result_cout, exp_cout);
        check("load_cycles", n_load, 1);
        check("rst_ff_cycles", n_rstff, 1);
        check("sipo_cycles", n_sipo, 8);
        check("sipo_first", first_sipo, 2);
        check("bit_cnt_seq", cnt_err, 0);
        check("busy_cycles", n_busy, 10);
        check("dp_a_held", dp_a, a);
        check("dp_b_held", dp_b, b);
    endtask

    task automatic release_result();
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("rel_valid", bus.result_valid, 0);
        check("rel_ready", bus.start_ready, 1);
    endtask

    initial begin
        int hold_err;
        int k;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.a_in         = '0;
        bus.b_in         = '0;
        bus.cin_in       = 1'b0;
        bus.result_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_start_ready", bus.start_ready, 1);
        check("rst_valid", bus.result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rst_shift", dp_rst_shift, 1);
        check("rst_load", dp_load, 0);
        check("rst_sipo", dp_sipo_load, 0);
        check("rst_sum", bus.result_sum, 0);
        check("rst_dp_a", dp_a, 0);

        do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        release_result();
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        release_result();
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        release_result();

        // Stray start mid-SHIFT must leave the latched operands alone.
        do_op(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 4);
        release_result();

        // Back-pressure: VALID holds for 10 cycles; a start pulse is ignored.
        do_op(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1, 0);
        hold_err = 0;
        for (k = 0; k < 10; k++) begin
            bus.start = (k == 4);
            bus.a_in  = 8'h01;
            bus.b_in  = 8'h02;
            tick();
            if (!bus.result_valid || bus.result_sum != 8'h1E || bus.start_ready) hold_err++;
        end
        bus.start = 1'b0;
        check("hold_errors", hold_err, 0);
        check("hold_dp_a", dp_a, 8'hC3);
        check("hold_valid", bus.result_valid, 1);
        release_result();
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);
        release_result();

        // Abort at bit_cnt 3.
        bus.start  = 1'b1;
        bus.a_in   = 8'h77;
        bus.b_in   = 8'h99;
        bus.cin_in = 1'b0;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (!(dp_sipo_load && bit_cnt == 4'd3) && k < 20) begin
            tick();
            k++;
        end
        check("abort_reach_cnt3", bit_cnt, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", bus.result_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rst_shift", dp_rst_shift, 1);
        check("abort_ready", bus.start_ready, 1);
        check("abort_bit_cnt", bit_cnt, 0);
        hold_err = 0;
        for (k = 0; k < 12; k++) begin
            tick();
            if (bus.result_valid || busy) hold_err++;
        end
        check("abort_quiet", hold_err, 0);
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);
        release_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
